// File: rtl/module2_bus_reader.sv
// Receive endpoint for the module2 parallel write bus: strobe settle FSM, parity/format check, FWFT result FIFO.
// Optional bit-4 format check storage is built when MODULE2_BUS_READER_FMT_CHECK_EN is defined.
module module2_bus_reader #(
   parameter int unsigned SETTLE_CYC = 2,
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned PARITY_ODD = 0
) (
   input  logic                   CLK,
   input  logic                   RST_N,
   input  logic                   READ,
   input  logic                   WRITE,
   input  logic [0:7]             BUS_D,
   input  logic                   BUS_P,
   output logic [0:7]             DOUT,
   output logic                   PERR,
   output logic                   FERR,
   output logic                   DVALID,
   input  logic                   DREADY,
   output logic                   OVF,
   input  logic                   OVF_CLR,
   output logic [$clog2(DEPTH):0] LEVEL
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;
   localparam int unsigned CW = $clog2(SETTLE_CYC + 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_HOLD   = 2'd2
   } state_t;

   state_t        state;
   state_t        state_next;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_next;
   logic          stb_q;
   logic          cap;
   logic          cap_p;

   logic [0:7]    mem_d [DEPTH];
   logic          mem_p [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr_next;
   logic [LW-1:0] level_next;
   logic          pop;
   logic          push;
   logic          ovf_set;
   logic          head_fwd;

   // Strobe register and FSM state register
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state <= ST_IDLE;
         cnt   <= '0;
         stb_q <= 1'b0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         stb_q <= WRITE & ~READ;
      end
   end

   // Next state: a strobe must survive SETTLE_CYC counted cycles before capture
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      case (state)
         ST_IDLE: begin
            if (stb_q) begin
               cnt_next   = CW'(1);
               state_next = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (!stb_q) begin
               state_next = ST_IDLE;
            end else if (cnt == CW'(SETTLE_CYC)) begin
               state_next = ST_HOLD;
            end else begin
               cnt_next = cnt + CW'(1);
            end
         end
         ST_HOLD: begin
            if (!stb_q) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // FSM output: single capture strobe per accepted pulse
   always_comb begin
      cap   = 1'b0;
      cap_p = (^BUS_D ^ BUS_P) != 1'(PARITY_ODD);
      if ((state == ST_SETTLE) && stb_q && (cnt == CW'(SETTLE_CYC))) begin
         cap = 1'b1;
      end
   end

   // FIFO control; a pop frees a full slot for a same-cycle push
   always_comb begin
      pop         = DVALID & DREADY;
      push        = cap & ((LEVEL != LW'(DEPTH)) | pop);
      ovf_set     = cap & ~push;
      rd_ptr_next = rd_ptr + AW'(pop);
      level_next  = LEVEL + LW'(push) - LW'(pop);
      head_fwd    = push & (rd_ptr_next == wr_ptr);
   end

   always_ff @(posedge CLK) begin
      if (push) begin
         mem_d[wr_ptr] <= BUS_D;
         mem_p[wr_ptr] <= cap_p;
      end
   end

   // Registered head view; holds the last head while empty
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         LEVEL  <= '0;
         DVALID <= 1'b0;
         OVF    <= 1'b0;
         DOUT   <= '0;
         PERR   <= 1'b0;
      end else begin
         rd_ptr <= rd_ptr_next;
         wr_ptr <= wr_ptr + AW'(push);
         LEVEL  <= level_next;
         DVALID <= (level_next != '0);
         OVF    <= ovf_set | (OVF & ~OVF_CLR);
         if (level_next != '0) begin
            DOUT <= head_fwd ? BUS_D : mem_d[rd_ptr_next];
            PERR <= head_fwd ? cap_p : mem_p[rd_ptr_next];
         end
      end
   end

`ifdef MODULE2_BUS_READER_FMT_CHECK_EN
   logic cap_f;
   logic mem_f [DEPTH];

   always_comb begin
      cap_f = BUS_D[4] != (BUS_D[0] & BUS_D[1]);
   end

   always_ff @(posedge CLK) begin
      if (push) begin
         mem_f[wr_ptr] <= cap_f;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         FERR <= 1'b0;
      end else if (level_next != '0) begin
         FERR <= head_fwd ? cap_f : mem_f[rd_ptr_next];
      end
   end
`else
   assign FERR = 1'b0;
`endif

endmodule

// File: tb/tb_module2_bus_reader.sv
// Directed bench for module2_bus_reader: queue-based reference model compared every cycle plus literal spot checks.
module tb_module2_bus_reader;

   localparam int unsigned SETTLE_CYC = 2;
   localparam int unsigned DEPTH      = 4;
   localparam int unsigned PARITY_ODD = 0;
   localparam int unsigned LW         = $clog2(DEPTH) + 1;

   logic          CLK     = 1'b0;
   logic          RST_N   = 1'b0;
   logic          READ    = 1'b0;
   logic          WRITE   = 1'b0;
   logic [0:7]    BUS_D   = '0;
   logic          BUS_P   = 1'b0;
   logic          DREADY  = 1'b0;
   logic          OVF_CLR = 1'b0;
   logic [0:7]    DOUT;
   logic          PERR;
   logic          FERR;
   logic          DVALID;
   logic          OVF;
   logic [LW-1:0] LEVEL;

   int n_vec = 0;
   int n_err = 0;

   module2_bus_reader #(
      .SETTLE_CYC(SETTLE_CYC),
      .DEPTH     (DEPTH),
      .PARITY_ODD(PARITY_ODD)
   ) dut (
      .CLK    (CLK),
      .RST_N  (RST_N),
      .READ   (READ),
      .WRITE  (WRITE),
      .BUS_D  (BUS_D),
      .BUS_P  (BUS_P),
      .DOUT   (DOUT),
      .PERR   (PERR),
      .FERR   (FERR),
      .DVALID (DVALID),
      .DREADY (DREADY),
      .OVF    (OVF),
      .OVF_CLR(OVF_CLR),
      .LEVEL  (LEVEL)
   );

   initial forever #5 CLK = ~CLK;

   typedef struct packed {
      logic [0:7] d;
      logic       p;
      logic       f;
   } ent_t;

   ent_t       mq[$];
   int         run = 0;
   logic [0:7] m_dout = '0;
   logic       m_perr = 1'b0;
   logic       m_ferr = 1'b0;
   logic       m_ovf  = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got 0x%0h, want 0x%0h", name, $time, act, exp);
      end
   endtask

   // Reference model: a pulse is a run of high strobe samples; capture SETTLE_CYC+1 edges after its first sample
   initial begin
      ent_t e;
      bit   cap;
      bit   ovf_ev;
      forever begin
         @(posedge CLK or negedge RST_N);
         if (!RST_N) begin
            run = 0;
            mq.delete();
            m_dout = '0;
            m_perr = 1'b0;
            m_ferr = 1'b0;
            m_ovf  = 1'b0;
         end else begin
            cap    = (run == int'(SETTLE_CYC) + 1);
            run    = (WRITE && !READ) ? run + 1 : 0;
            ovf_ev = 1'b0;
            if (mq.size() != 0 && DREADY) void'(mq.pop_front());
            if (cap) begin
               e.d = BUS_D;
               e.p = (^BUS_D ^ BUS_P) != 1'(PARITY_ODD);
`ifdef MODULE2_BUS_READER_FMT_CHECK_EN
               e.f = BUS_D[4] != (BUS_D[0] & BUS_D[1]);
`else
               e.f = 1'b0;
`endif
               if (mq.size() < int'(DEPTH)) mq.push_back(e);
               else ovf_ev = 1'b1;
            end
            if (ovf_ev) m_ovf = 1'b1;
            else if (OVF_CLR) m_ovf = 1'b0;
            if (mq.size() != 0) begin
               m_dout = mq[0].d;
               m_perr = mq[0].p;
               m_ferr = mq[0].f;
            end
         end
      end
   end

   // Every-cycle comparison against the model, away from the active edge
   initial forever begin
      @(negedge CLK);
      check("dout",   32'(DOUT),   32'(m_dout));
      check("perr",   32'(PERR),   32'(m_perr));
      check("ferr",   32'(FERR),   32'(m_ferr));
      check("dvalid", 32'(DVALID), 32'(mq.size() != 0));
      check("ovf",    32'(OVF),    32'(m_ovf));
      check("level",  32'(LEVEL),  32'(mq.size()));
   end

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic send(input logic [0:7] d, input logic p, input int hi, input int gap);
      BUS_D = d;
      BUS_P = p;
      WRITE = 1'b1;
      tick(hi);
      WRITE = 1'b0;
      tick(gap);
   endtask

   task automatic pop_one();
      DREADY = 1'b1;
      tick(1);
      DREADY = 1'b0;
   endtask

   initial begin
      logic [0:7] v;
      logic       exp_f;

      // Reset then idle
      tick(3);
      check("rst_dout",   32'(DOUT),   32'h0);
      check("rst_dvalid", 32'(DVALID), 32'h0);
      check("rst_ovf",    32'(OVF),    32'h0);
      check("rst_level",  32'(LEVEL),  32'h0);
      check("rst_perr",   32'(PERR),   32'h0);
      check("rst_ferr",   32'(FERR),   32'h0);
      RST_N = 1'b1;
      tick(10);
      check("idle_dvalid", 32'(DVALID), 32'h0);

      // Clean write, correct even parity: DVALID rises after edge 3
      BUS_D = 8'b1101_1000;
      BUS_P = 1'b0;
      WRITE = 1'b1;
      tick(3);
      check("lat_edge2_dvalid", 32'(DVALID), 32'h0);
      tick(1);
      check("lat_edge3_dvalid", 32'(DVALID), 32'h1);
      check("clean_dout",  32'(DOUT),  32'hD8);
      check("clean_perr",  32'(PERR),  32'h0);
      check("clean_ferr",  32'(FERR),  32'h0);
      check("clean_level", 32'(LEVEL), 32'h1);
      tick(2);
      WRITE = 1'b0;
      tick(3);
      check("one_capture_level", 32'(LEVEL), 32'h1);
      pop_one();
      check("pop_level",     32'(LEVEL), 32'h0);
      check("empty_hold_dout", 32'(DOUT), 32'hD8);

      // Same data, wrong parity bit
      send(8'b1101_1000, 1'b1, 4, 2);
      check("bad_par_perr", 32'(PERR), 32'h1);
      pop_one();

      // Bit 4 set with bit 1 clear, parity also wrong
`ifdef MODULE2_BUS_READER_FMT_CHECK_EN
      exp_f = 1'b1;
`else
      exp_f = 1'b0;
`endif
      send(8'b1000_1000, 1'b1, 4, 2);
      check("err_perr", 32'(PERR), 32'h1);
      check("err_ferr", 32'(FERR), 32'(exp_f));
      pop_one();

      // Runt strobe and READ masking
      WRITE = 1'b1;
      tick(2);
      WRITE = 1'b0;
      tick(5);
      check("runt_level", 32'(LEVEL), 32'h0);
      READ  = 1'b1;
      WRITE = 1'b1;
      tick(8);
      READ  = 1'b0;
      WRITE = 1'b0;
      tick(3);
      check("read_mask_level", 32'(LEVEL), 32'h0);

      // Overflow with five strobes into a four-entry FIFO
      for (int i = 1; i <= 5; i++) begin
         v = 8'(i);
         send(v, ^v, 4, 2);
      end
      check("ovf_level", 32'(LEVEL), 32'h4);
      check("ovf_set",   32'(OVF),   32'h1);
      for (int i = 1; i <= 4; i++) begin
         check("ovf_drain_dout", 32'(DOUT), 32'(i));
         pop_one();
      end
      check("ovf_drain_level", 32'(LEVEL), 32'h0);
      check("ovf_sticky",      32'(OVF),   32'h1);
      OVF_CLR = 1'b1;
      tick(1);
      OVF_CLR = 1'b0;
      check("ovf_clr", 32'(OVF), 32'h0);

      // Full FIFO with push and pop on the same edge
      for (int i = 0; i < 4; i++) begin
         v = 8'(8'h10 + i);
         send(v, ^v, 4, 2);
      end
      check("full_level", 32'(LEVEL), 32'h4);
      BUS_D = 8'h14;
      BUS_P = 1'b0;
      WRITE = 1'b1;
      tick(3);
      DREADY = 1'b1;
      tick(1);
      DREADY = 1'b0;
      WRITE  = 1'b0;
      check("full_pp_level", 32'(LEVEL), 32'h4);
      check("full_pp_ovf",   32'(OVF),   32'h0);
      check("full_pp_dout",  32'(DOUT),  32'h11);
      tick(2);

      // Overflow in the same cycle as OVF_CLR keeps OVF set
      BUS_D = 8'h55;
      WRITE = 1'b1;
      tick(3);
      OVF_CLR = 1'b1;
      tick(1);
      OVF_CLR = 1'b0;
      WRITE   = 1'b0;
      check("ovf_beats_clr", 32'(OVF), 32'h1);
      tick(2);
      OVF_CLR = 1'b1;
      tick(1);
      OVF_CLR = 1'b0;
      check("ovf_clr2", 32'(OVF), 32'h0);
      for (int i = 0; i < 4; i++) begin
         check("full_drain_dout", 32'(DOUT), 32'(8'h11 + i));
         pop_one();
      end

      // Back-to-back pulses at the minimum length and gap
      for (int i = 0; i < 3; i++) begin
         v = 8'(8'hA0 + i);
         send(v, 1'b0, 3, 1);
      end
      tick(2);
      check("b2b_level", 32'(LEVEL), 32'h3);
      for (int i = 0; i < 3; i++) begin
         check("b2b_dout", 32'(DOUT), 32'(8'hA0 + i));
         pop_one();
      end

      // Reset during SETTLE loses the word
      BUS_D = 8'h77;
      WRITE = 1'b1;
      tick(2);
      RST_N = 1'b0;
      WRITE = 1'b0;
      tick(2);
      RST_N = 1'b1;
      tick(6);
      check("rst_settle_level",  32'(LEVEL),  32'h0);
      check("rst_settle_dvalid", 32'(DVALID), 32'h0);

      // Strobe held across reset release counts as a new pulse
      BUS_D = 8'h3C;
      WRITE = 1'b1;
      RST_N = 1'b0;
      tick(2);
      RST_N = 1'b1;
      tick(5);
      WRITE = 1'b0;
      tick(2);
      check("rst_hold_level", 32'(LEVEL), 32'h1);
      check("rst_hold_dout",  32'(DOUT),  32'h3C);
      pop_one();
      tick(3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
